// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder slice stepped LSB first across WIDTH bits.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN (adds the sub port).

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module full_adder_slice (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (.x(x),  .y(y),   .s(s0), .c(c0));
    half_adder u_ha1 (.x(s0), .y(cin), .s(s),  .c(c1));

    assign cout = c0 | c1;
endmodule

// state | meaning
// IDLE  | waiting for start; operands latched when it is accepted
// RUN   | one bit step per cycle, LSB first, WIDTH cycles
// DONE  | single cycle; sum/carry just updated, done pulses
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             c;
    logic             sub_q;
    logic             bit_b;
    logic             bit_s;
    logic             bit_c;

`ifndef SERIAL_ADDER_SUB_EN
    assign sub_q = 1'b0;
`endif

    // Subtraction adds the one's complement of b with the carry seeded to 1.
    assign bit_b = sb[0] ^ sub_q;

    full_adder_slice u_slice (
        .x    (sa[0]),
        .y    (bit_b),
        .cin  (c),
        .s    (bit_s),
        .cout (bit_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            cnt   <= '0;
            c     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            carry <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        res   <= '0;
                        cnt   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
                        sub_q <= sub;
                        c     <= sub;
`else
                        c     <= 1'b0;
`endif
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sa  <= {1'b0, sa[WIDTH-1:1]};
                    sb  <= {1'b0, sb[WIDTH-1:1]};
                    res <= {bit_s, res[WIDTH-1:1]};
                    c   <= bit_c;
                    cnt <= cnt + 1'b1;
                    // Last step: publish the completed word, never a partial one.
                    if (cnt == LAST_STEP) begin
                        sum   <= {bit_s, res[WIDTH-1:1]};
                        carry <= bit_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: WIDTH=8 directed cases plus an exhaustive WIDTH=4 sweep.

module tb_serial_adder_ctrl;
    logic       clk;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       sub8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       carry8;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       sub4;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       carry4;

    int tests;
    int fails;
    logic [7:0] last_sum;
    logic       last_carry;

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub8),
`endif
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .carry (carry8)
    );

    serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub4),
`endif
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .carry (carry4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 operation with fixed-cycle checks; hammer keeps start high through RUN and DONE.
    task automatic op8(input logic [7:0] oa, input logic [7:0] ob, input logic osub,
                       input logic [7:0] es, input logic ec, input bit hammer);
        @(negedge clk);
        start8 = 1'b1;
        a8     = oa;
        b8     = ob;
        sub8   = osub;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (hammer) begin
                start8 = 1'b1;
                a8     = 8'($urandom);
                b8     = 8'($urandom);
                sub8   = ~osub;
            end else begin
                start8 = 1'b0;
                a8     = ~oa;
                b8     = ~ob;
            end
            check("run_busy", 32'(busy8), 32'd1);
            check("run_done", 32'(done8), 32'd0);
            check("run_sum_hold", 32'(sum8), 32'(last_sum));
            check("run_carry_hold", 32'(carry8), 32'(last_carry));
        end
        @(negedge clk);
        check("done_pulse", 32'(done8), 32'd1);
        check("done_busy", 32'(busy8), 32'd0);
        check("done_sum", 32'(sum8), 32'(es));
        check("done_carry", 32'(carry8), 32'(ec));
        last_sum   = es;
        last_carry = ec;
        start8 = hammer;
        @(negedge clk);
        start8 = 1'b0;
        check("post_done_low", 32'(done8), 32'd0);
        check("post_busy_low", 32'(busy8), 32'd0);
        @(negedge clk);
        check("no_queued_start", 32'(busy8), 32'd0);
        check("result_held", 32'(sum8), 32'(es));
    endtask

    initial begin
        logic [4:0] ref4;
        tests = 0;
        fails = 0;
        last_sum = 8'h00;
        last_carry = 1'b0;
        rst_n = 1'b0;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; sub8 = 1'b0;
        start4 = 1'b0; a4 = 4'h0;  b4 = 4'h0;  sub4 = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_sum", 32'(sum8), 32'd0);
        check("rst_carry", 32'(carry8), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        op8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        op8(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0);
        op8(8'h80, 8'h90, 1'b0, 8'h10, 1'b1, 1'b1);
        op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
        op8(8'h99, 8'h99, 1'b0, 8'h32, 1'b1, 1'b1);

        // Reset in the middle of RUN discards the operation.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h3C; b8 = 8'h0F;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start8 = 1'b0;
            check("abort_run_busy", 32'(busy8), 32'd1);
        end
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_sum", 32'(sum8), 32'd0);
        check("abort_carry", 32'(carry8), 32'd0);
        last_sum = 8'h00;
        last_carry = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op8(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        op8(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        op8(8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0);
        op8(8'h07, 8'h05, 1'b0, 8'h0C, 1'b0, 1'b0);
`endif

        // Exhaustive WIDTH=4 sweep against a plain integer reference.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                ref4 = 5'(i) + 5'(j);
                @(negedge clk);
                start4 = 1'b1;
                a4 = 4'(i);
                b4 = 4'(j);
                sub4 = 1'b0;
                for (int k = 1; k <= 4; k++) begin
                    @(negedge clk);
                    start4 = 1'b0;
                    a4 = 4'(j);
                    b4 = 4'(i + 3);
                    check("w4_busy", 32'(busy4), 32'd1);
                    check("w4_no_early_done", 32'(done4), 32'd0);
                end
                @(negedge clk);
                check("w4_done", 32'(done4), 32'd1);
                check("w4_sum", 32'(sum4), 32'(ref4[3:0]));
                check("w4_carry", 32'(carry4), 32'(ref4[4]));
                @(negedge clk);
                check("w4_done_single", 32'(done4), 32'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
